// File: rtl/exp_wrap_pkg.sv
// ============================================================================
// exp_wrap_pkg
// Shared state encoding, default widths and sizing helpers for the
// exponential-accelerator input wrapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package exp_wrap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int unsigned c_data_w = 16;
  localparam int unsigned c_depth  = 4;

  // Occupancy counter must represent 0..depth inclusive
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned c_fifo_cnt_w = fifo_cnt_w(c_depth);

endpackage

`default_nettype wire

// File: rtl/exp_input_wrapper_if.sv
// ============================================================================
// exp_input_wrapper_if
// Producer handshake and accelerator launch signals of the input wrapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface exp_input_wrapper_if
  import exp_wrap_pkg::*;
#(
  parameter int DATA_W = c_data_w
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              exp_start;
  logic [DATA_W-1:0] exp_x;
  logic              exp_done;

  modport slave (
    input  in_valid, in_data, exp_done,
    output in_ready, exp_start, exp_x
  );

  modport master (
    output in_valid, in_data, exp_done,
    input  in_ready, exp_start, exp_x
  );

endinterface

`default_nettype wire

// File: rtl/exp_sync_fifo.sv
// ============================================================================
// exp_sync_fifo
// Single-clock FIFO; full/empty derived from an occupancy counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exp_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [DATA_W-1:0]        din,
  output logic      [DATA_W-1:0]        dout,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_wptr;
  logic [c_aw-1:0]   r_rptr;
  logic [c_cw-1:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == c_cw'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked by the counter
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_aw'(1);
      if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/exp_input_wrapper.sv
// ============================================================================
// exp_input_wrapper
// Buffers operands and launches them one at a time into the exp accelerator.
// Optional macro EXP_IN_BYPASS_EN: an operand accepted while idle and empty
// skips the FIFO and starts one cycle after acceptance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exp_input_wrapper
  import exp_wrap_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  exp_input_wrapper_if.slave                 bus,
  output logic                               busy,
  output logic [fifo_cnt_w(DEPTH)-1:0]       fifo_count,
  output logic [CNT_W-1:0]                   job_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_x;
  logic [CNT_W-1:0]  r_job_cnt;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_bypass;
  logic              w_pop;
  logic              w_job_inc;
  logic [DATA_W-1:0] w_fifo_dout;

  assign w_accept     = bus.in_valid && !w_full;
  assign bus.in_ready = !w_full;
  assign bus.exp_start = (r_state == START);
  assign bus.exp_x    = r_x;
  assign busy         = (r_state != IDLE);
  assign job_cnt      = r_job_cnt;

`ifdef EXP_IN_BYPASS_EN
  assign w_bypass = w_accept && (r_state == IDLE) && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  exp_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept && !w_bypass),
    .pop   (w_pop),
    .din   (bus.in_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_job_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end else if (w_bypass) begin
          w_state_nxt = START;
        end
      end
      START: w_state_nxt = WAIT;
      WAIT: begin
        // Completion only counts once the accelerator has actually been launched
        if (bus.exp_done) begin
          w_job_inc   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_job_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop)         r_x <= w_fifo_dout;
      else if (w_bypass) r_x <= bus.in_data;
      if (w_job_inc)     r_job_cnt <= r_job_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
